// File: rtl/prg_monitor_if.sv
// ============================================================================
// Module      : prg_monitor_if
// Description : Byte-stream (rx/tx) and memory programming port bundle that
//               connects prg_monitor to the UART blocks and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prg_monitor_if;
  // Serial receive side
  logic [7:0] rx_data;
  logic       rx_valid;
  // Serial transmit side
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  // Memory programming port
  logic       prg_we;
  logic [7:0] prg_MA;
  logic [7:0] prg_WD;
  logic [7:0] prg_RD;
  // Status
  logic       busy;
  logic       rx_drop;

  // The monitor drives the memory port and the transmit byte
  modport master (
    input  rx_data, rx_valid, tx_ready, prg_RD,
    output tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, rx_drop
  );

  // The environment (UART blocks + memory) sees the mirror image
  modport slave (
    output rx_data, rx_valid, tx_ready, prg_RD,
    input  tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, rx_drop
  );
endinterface

`default_nettype wire

// File: rtl/prg_monitor.sv
// ============================================================================
// Module      : prg_monitor
// Description : Command parser driving the memory programming port. Accepts
//               'W' addr data, 'R' addr and 'D' addr len byte commands and
//               returns ACK / read data / dump data / NAK bytes on the tx side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prg_monitor #(
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] CMD_WRITE    = 8'h57,
  parameter logic [7:0] CMD_READ     = 8'h52,
  parameter logic [7:0] CMD_DUMP     = 8'h44,
  parameter logic [7:0] ACK_BYTE     = 8'h06,
  parameter logic [7:0] NAK_BYTE     = 8'h15
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  prg_monitor_if.master bus
);

  // Wide enough to count 0..READ_LATENCY inclusive
  localparam int LAT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_GET_LEN  = 3'd3,
    S_WRITE    = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_SEND     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       ma_q, ma_d;
  logic [7:0]       wd_q, wd_d;
  logic             we_q, we_d;
  logic [8:0]       cnt_q, cnt_d;        // remaining dump bytes, 256 needs 9 bits
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             wph_q, wph_d;        // WRITE: 0 = strobe cycle, 1 = reply cycle
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  logic             is_cmd;
  logic             busy_now;

  assign is_cmd   = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ) ||
                    (bus.rx_data == CMD_DUMP);
  assign busy_now = (state_q == S_WRITE) || (state_q == S_RD_WAIT) ||
                    (state_q == S_SEND);

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ma_d       = ma_q;
    wd_d       = wd_q;
    we_d       = 1'b0;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    wph_d      = wph_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    drop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (is_cmd) begin
            cmd_d   = bus.rx_data;
            state_d = S_GET_ADDR;
          end else begin
            // Unknown opcode: clear cmd so SEND never mistakes this for a dump
            cmd_d      = 8'h00;
            cnt_d      = 9'd0;
            tx_data_d  = NAK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = S_SEND;
          end
        end
      end

      S_GET_ADDR: begin
        if (bus.rx_valid) begin
          ma_d = bus.rx_data;
          if (cmd_q == CMD_WRITE) begin
            state_d = S_GET_DATA;
          end else if (cmd_q == CMD_READ) begin
            cnt_d   = 9'd1;
            lat_d   = '0;
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_GET_LEN;
          end
        end
      end

      S_GET_DATA: begin
        if (bus.rx_valid) begin
          wd_d    = bus.rx_data;
          wph_d   = 1'b0;
          state_d = S_WRITE;
        end
      end

      S_GET_LEN: begin
        if (bus.rx_valid) begin
          cnt_d   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          lat_d   = '0;
          state_d = S_RD_WAIT;
        end
      end

      S_WRITE: begin
        // Two cycles: raise the strobe, then drop it and queue the ACK
        if (!wph_q) begin
          we_d  = 1'b1;
          wph_d = 1'b1;
        end else begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end
      end

      S_RD_WAIT: begin
        // Address has been stable since entry; memory data is valid by now
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          tx_data_d  = bus.prg_RD;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if ((cmd_q == CMD_DUMP) && (cnt_q > 9'd1)) begin
            cnt_d   = cnt_q - 9'd1;
            ma_d    = ma_q + 8'd1;   // natural 8-bit wrap FF -> 00
            lat_d   = '0;
            state_d = S_RD_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while working on a command are discarded and flagged
    if (busy_now && bus.rx_valid) begin
      drop_d = 1'b1;
    end

    busy_d = (state_d == S_WRITE) || (state_d == S_RD_WAIT) || (state_d == S_SEND);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      ma_q       <= 8'h00;
      wd_q       <= 8'h00;
      we_q       <= 1'b0;
      cnt_q      <= 9'd0;
      lat_q      <= '0;
      wph_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ma_q       <= ma_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      wph_q      <= wph_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.prg_we   = we_q;
  assign bus.prg_MA   = ma_q;
  assign bus.prg_WD   = wd_q;
  assign bus.busy     = busy_q;
  assign bus.rx_drop  = drop_q;

endmodule

`default_nettype wire
